// File: rtl/poly_mul_stage1.sv
// poly_mul_stage1: sequential 5x5 coefficient polynomial multiplier mod 2^W,
// one B coefficient per cycle, producing raw product coefficients s0..s8.
module poly_mul_stage1 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] a2,
   input  logic [W-1:0] a3,
   input  logic [W-1:0] a4,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] b1,
   input  logic [W-1:0] b2,
   input  logic [W-1:0] b3,
   input  logic [W-1:0] b4,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] s0,
   output logic [W-1:0] s1,
   output logic [W-1:0] s2,
   output logic [W-1:0] s3,
   output logic [W-1:0] s4,
   output logic [W-1:0] s5,
   output logic [W-1:0] s6,
   output logic [W-1:0] s7,
   output logic [W-1:0] s8
);
   typedef enum logic {IDLE, MAC} state_t;
   state_t                state_q, state_d;
   logic [4:0][W-1:0]     a_q, a_d, b_q, b_d;
   logic [8:0][W-1:0]     acc_q, acc_d, s_q, s_d;
   logic [2:0]            k_q, k_d;
   logic                  done_q, done_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         s_q     <= '0;
         k_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         k_q     <= k_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      s_d     = s_q;
      k_d     = k_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            a_d     = {a4, a3, a2, a1, a0};
            b_d     = {b4, b3, b2, b1, b0};
            acc_d   = '0;
            k_d     = '0;
            state_d = MAC;
         end
      end else begin
         // each a_i lands in a distinct column i+k, so the adds never collide
         for (int i = 0; i < 5; i++)
            acc_d[4'(i) + 4'(k_q)] = acc_q[4'(i) + 4'(k_q)] + a_q[i] * b_q[k_q];
         k_d = k_q + 3'd1;
         if (k_q == 3'd4) begin
            s_d     = acc_d;
            done_d  = 1'b1;
            k_d     = '0;
            state_d = IDLE;
         end
      end
   end

   assign busy = (state_q == MAC);
   assign done = done_q;
   assign {s8, s7, s6, s5, s4, s3, s2, s1, s0} = s_q;
endmodule

// File: tb/tb_poly_mul_stage1.sv
// tb_poly_mul_stage1: directed checks of the sequential polynomial multiplier.
module tb_poly_mul_stage1;
   logic clk = 1'b0;
   logic reset, start;
   logic [7:0] a0, a1, a2, a3, a4, b0, b1, b2, b3, b4;
   logic busy, done;
   logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7, s8;
   logic [8:0][7:0] s_all;
   int passed = 0;
   int total = 0;

   assign s_all = {s8, s7, s6, s5, s4, s3, s2, s1, s0};

   always #5 clk = ~clk;

   poly_mul_stage1 #(.W(8)) dut (
      .clk(clk), .reset(reset), .start(start),
      .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
      .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4),
      .busy(busy), .done(done),
      .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4),
      .s5(s5), .s6(s6), .s7(s7), .s8(s8)
   );

   task automatic set_ops(input logic [4:0][7:0] a, input logic [4:0][7:0] b);
      {a4, a3, a2, a1, a0} = a;
      {b4, b3, b2, b1, b0} = b;
   endtask

   // pulse start, then wait for done; reports busy cycles seen and whether done arrived
   task automatic do_mul(input logic [4:0][7:0] a, input logic [4:0][7:0] b,
                         output int bcnt, output bit ok);
      @(negedge clk);
      set_ops(a, b);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bcnt = 0;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) bcnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      set_ops('0, '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
      total++;
      if (s_all !== 72'h0) $display("FAIL reset_s: got %h want 0", s_all); else passed++;
   endtask

   task automatic test_basic();
      int bc;
      bit ok;
      logic [8:0][7:0] exp;
      exp = {8'd5, 8'd9, 8'd12, 8'd14, 8'd15, 8'd10, 8'd6, 8'd3, 8'd1};
      do_mul({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {5{8'd1}}, bc, ok);
      total++;
      if (!ok) $display("FAIL basic_timeout: got no done want done"); else passed++;
      total++;
      if (bc != 5) $display("FAIL basic_busy_cycles: got %0d want 5", bc); else passed++;
      total++;
      if (s_all !== exp) $display("FAIL basic_s: got %h want %h", s_all, exp); else passed++;
      @(negedge clk);
      total++;
      if (done !== 1'b0) $display("FAIL basic_done_width: got %b want 0", done); else passed++;
      total++;
      if (s_all !== exp) $display("FAIL basic_s_hold: got %h want %h", s_all, exp); else passed++;
   endtask

   task automatic test_wrap();
      int bc;
      bit ok;
      logic [8:0][7:0] exp;
      do_mul({32'h0, 8'd255}, {32'h0, 8'd255}, bc, ok);
      exp = 72'h01;
      total++;
      if (!ok || s_all !== exp) $display("FAIL wrap_single: got %h want %h", s_all, exp); else passed++;
      do_mul({5{8'd255}}, {5{8'd255}}, bc, ok);
      exp = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      total++;
      if (!ok || s_all !== exp) $display("FAIL wrap_all: got %h want %h", s_all, exp); else passed++;
   endtask

   task automatic test_ignore_start();
      int dcnt = 0;
      logic [8:0][7:0] cap, exp;
      cap = '0;
      exp = {8'd5, 8'd9, 8'd12, 8'd14, 8'd15, 8'd10, 8'd6, 8'd3, 8'd1};
      @(negedge clk);
      set_ops({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {5{8'd1}});
      start = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         start = (c == 1);
         if (c == 1) set_ops({5{8'd7}}, {5{8'd9}});
         if (c == 3) set_ops({5{8'd3}}, {5{8'd11}});
         if (done) begin
            dcnt++;
            cap = s_all;
         end
      end
      total++;
      if (dcnt != 1) $display("FAIL ignore_done_count: got %0d want 1", dcnt); else passed++;
      total++;
      if (cap !== exp) $display("FAIL ignore_s: got %h want %h", cap, exp); else passed++;
   endtask

   task automatic test_reset_mid();
      int bc;
      bit ok;
      int dcnt = 0;
      logic [8:0][7:0] exp;
      @(negedge clk);
      set_ops({5{8'd1}}, {5{8'd1}});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++;
      if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
      total++;
      if (s_all !== 72'h0) $display("FAIL midrst_s: got %h want 0", s_all); else passed++;
      for (int c = 0; c < 6; c++) begin
         if (done) dcnt++;
         @(negedge clk);
      end
      total++;
      if (dcnt != 0) $display("FAIL midrst_no_done: got %0d want 0", dcnt); else passed++;
      do_mul({32'h0, 8'd2}, {8'd3, 32'h0}, bc, ok);
      exp = {32'h0, 8'd6, 32'h0};
      total++;
      if (!ok || s_all !== exp) $display("FAIL midrst_next: got %h want %h", s_all, exp); else passed++;
   endtask

   task automatic test_back_to_back();
      int last = -1;
      int ndone = 0;
      int bad_gap = 0;
      int bad_s = 0;
      logic [8:0][7:0] exp;
      exp = {48'h0, 8'd1, 8'd2, 8'd1};
      @(negedge clk);
      set_ops({24'h0, 8'd1, 8'd1}, {24'h0, 8'd1, 8'd1});
      start = 1'b1;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (s_all !== exp) bad_s++;
            if (last >= 0 && c - last != 6) bad_gap++;
            last = c;
         end
      end
      start = 1'b0;
      total++;
      if (ndone < 4) $display("FAIL b2b_count: got %0d want >=4", ndone); else passed++;
      total++;
      if (bad_gap != 0) $display("FAIL b2b_period: got %0d bad gaps want 0", bad_gap); else passed++;
      total++;
      if (bad_s != 0) $display("FAIL b2b_s: got %0d bad results want 0", bad_s); else passed++;
      repeat (8) @(negedge clk);
      total++;
      if (busy !== 1'b0) $display("FAIL b2b_drain: got busy %b want 0", busy); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
